calc_sequencer: RTL and testbench

Control FSM between the debounced front-panel buttons and the float compute unit in `main`. It collects four 16-bit switch words into two 32-bit operands, issues a one-cycle start to the compute unit, and waits for done with a timeout. It then steps the display through result pages on each next-press. A clear-press restarts entry at any time.

---
 rtl/calc_pkg.sv | 17 +
 rtl/timeout_counter.sv | 30 +++
 rtl/calc_sequencer.sv | 127 ++++++++++++
 tb/tb_calc_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding, status codes and widths for the calc sequencer
package calc_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SHOW  = 2'd3
    } calc_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int WORD_W = 16;
    localparam int OPER_W = 32;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - cycle counter that flags the last allowed WAIT cycle
module timeout_counter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] count;

    // Count enabled cycles; clear wins so a fresh wait always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // High during the cycle in which the count sits on its final value
    assign expired = (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - operand entry, compute handshake and result paging FSM
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int N_PAGES     = 7,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_pulse,
    input  logic        nxt_pulse,
    input  logic        clr_pulse,
    input  logic [15:0] data_in,
    input  logic        calc_done,
    input  logic [1:0]  calc_err,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        start,
    output logic        ready,
    output logic [1:0]  word_idx,
    output logic [2:0]  page,
    output logic        show,
    output logic [1:0]  err_out
);

    calc_state_t state, state_n;
    logic [1:0]  word_idx_n;
    logic [31:0] op_a_n, op_b_n;
    logic [2:0]  page_n;
    logic [1:0]  err_n;
    logic        tmo_clear, tmo_enable, tmo_expired;

    // The counter restarts on entry to WAIT and on a clear, and only runs while waiting for done
    assign tmo_clear  = clr_pulse || (state == S_START);
    assign tmo_enable = (state == S_WAIT) && !calc_done;

    timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    // Next-state and next-value logic; clear overrides every state
    always_comb begin
        state_n    = state;
        word_idx_n = word_idx;
        op_a_n     = op_a;
        op_b_n     = op_b;
        page_n     = page;
        err_n      = err_out;

        if (clr_pulse) begin
            state_n    = S_LOAD;
            word_idx_n = 2'd0;
            op_a_n     = '0;
            op_b_n     = '0;
            page_n     = 3'd0;
            err_n      = ERR_OK;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_pulse) begin
                        case (word_idx)
                            2'd0:    op_a_n[31:16] = data_in;
                            2'd1:    op_a_n[15:0]  = data_in;
                            2'd2:    op_b_n[31:16] = data_in;
                            default: op_b_n[15:0]  = data_in;
                        endcase
                        word_idx_n = word_idx + 2'd1;
                        if (word_idx == 2'd3) begin
                            state_n = S_START;
                        end
                    end
                end
                S_START: begin
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (calc_done) begin
                        err_n   = calc_err;
                        page_n  = 3'd0;
                        state_n = S_SHOW;
                    end else if (tmo_expired) begin
                        err_n   = ERR_TIMEOUT;
                        page_n  = 3'd0;
                        state_n = S_SHOW;
                    end
                end
                default: begin
                    if (nxt_pulse) begin
                        page_n = (page == 3'(N_PAGES - 1)) ? 3'd0 : page + 3'd1;
                    end
                end
            endcase
        end
    end

    // State, data and flag registers; flags are decoded from the next state so every output is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD;
            word_idx <= 2'd0;
            op_a     <= '0;
            op_b     <= '0;
            page     <= 3'd0;
            err_out  <= ERR_OK;
            start    <= 1'b0;
            ready    <= 1'b1;
            show     <= 1'b0;
        end else begin
            state    <= state_n;
            word_idx <= word_idx_n;
            op_a     <= op_a_n;
            op_b     <= op_b_n;
            page     <= page_n;
            err_out  <= err_n;
            start    <= (state_n == S_START);
            ready    <= (state_n == S_LOAD);
            show     <= (state_n == S_SHOW);
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - randomized and directed checks of calc_sequencer against a behavioural model
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_pulse = 1'b0;
    logic        nxt_pulse = 1'b0;
    logic        clr_pulse = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        calc_done = 1'b0;
    logic [1:0]  calc_err = 2'b00;

    logic [31:0] op_a_o [2];
    logic [31:0] op_b_o [2];
    logic        start_o [2];
    logic        ready_o [2];
    logic [1:0]  idx_o [2];
    logic [2:0]  page_o [2];
    logic        show_o [2];
    logic [1:0]  err_o [2];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.N_PAGES(7), .TIMEOUT_CYC(1024)) dut_long (
        .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .nxt_pulse(nxt_pulse),
        .clr_pulse(clr_pulse), .data_in(data_in), .calc_done(calc_done), .calc_err(calc_err),
        .op_a(op_a_o[0]), .op_b(op_b_o[0]), .start(start_o[0]), .ready(ready_o[0]),
        .word_idx(idx_o[0]), .page(page_o[0]), .show(show_o[0]), .err_out(err_o[0])
    );

    calc_sequencer #(.N_PAGES(7), .TIMEOUT_CYC(16)) dut_short (
        .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .nxt_pulse(nxt_pulse),
        .clr_pulse(clr_pulse), .data_in(data_in), .calc_done(calc_done), .calc_err(calc_err),
        .op_a(op_a_o[1]), .op_b(op_b_o[1]), .start(start_o[1]), .ready(ready_o[1]),
        .word_idx(idx_o[1]), .page(page_o[1]), .show(show_o[1]), .err_out(err_o[1])
    );

    // Behavioural model: phase of the transaction, the four entered words, and cycles spent waiting
    localparam int M_LOAD = 0, M_START = 1, M_WAIT = 2, M_SHOW = 3;
    int          tmo [2] = '{1024, 16};
    int          m_mode [2] = '{M_LOAD, M_LOAD};
    int          m_idx [2] = '{0, 0};
    int          m_page [2] = '{0, 0};
    int          m_err [2] = '{0, 0};
    int          m_waited [2] = '{0, 0};
    logic [15:0] m_w [2][4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || clr_pulse) begin
                m_mode[i] = M_LOAD; m_idx[i] = 0; m_page[i] = 0; m_err[i] = 0; m_waited[i] = 0;
                for (int j = 0; j < 4; j++) m_w[i][j] = 16'h0;
            end else begin
                case (m_mode[i])
                    M_LOAD: if (in_pulse) begin
                        m_w[i][m_idx[i]] = data_in;
                        if (m_idx[i] == 3) begin m_idx[i] = 0; m_mode[i] = M_START; end
                        else m_idx[i] = m_idx[i] + 1;
                    end
                    M_START: begin m_mode[i] = M_WAIT; m_waited[i] = 0; end
                    M_WAIT: begin
                        if (calc_done) begin m_err[i] = int'(calc_err); m_page[i] = 0; m_mode[i] = M_SHOW; end
                        else if (m_waited[i] == tmo[i] - 1) begin m_err[i] = 3; m_page[i] = 0; m_mode[i] = M_SHOW; end
                        else m_waited[i] = m_waited[i] + 1;
                    end
                    default: if (nxt_pulse) m_page[i] = (m_page[i] + 1) % 7;
                endcase
            end
        end
    end

    // Compare every output of both instances against the model each cycle, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("op_a[%0d]", i), op_a_o[i], {m_w[i][0], m_w[i][1]});
            chk($sformatf("op_b[%0d]", i), op_b_o[i], {m_w[i][2], m_w[i][3]});
            chk($sformatf("start[%0d]", i), 32'(start_o[i]), 32'(m_mode[i] == M_START));
            chk($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(m_mode[i] == M_LOAD));
            chk($sformatf("show[%0d]", i), 32'(show_o[i]), 32'(m_mode[i] == M_SHOW));
            chk($sformatf("word_idx[%0d]", i), 32'(idx_o[i]), 32'(m_idx[i]));
            chk($sformatf("page[%0d]", i), 32'(page_o[i]), 32'(m_page[i]));
            chk($sformatf("err_out[%0d]", i), 32'(err_o[i]), 32'(m_err[i]));
        end
    end

    task automatic cyc(input logic i, input logic n, input logic c, input logic [15:0] d,
                       input logic dn, input logic [1:0] e);
        @(negedge clk);
        in_pulse = i; nxt_pulse = n; clr_pulse = c; data_in = d; calc_done = dn; calc_err = e;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0, 2'($urandom));
    endtask

    task automatic load4(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
        cyc(1'b1, 1'b0, 1'b0, w0, 1'b0, 2'b00); idle();
        cyc(1'b1, 1'b1, 1'b0, w1, 1'b0, 2'b00); idle();
        cyc(1'b1, 1'b0, 1'b0, w2, 1'b0, 2'b00); idle();
        cyc(1'b1, 1'b0, 1'b0, w3, 1'b0, 2'b00); idle();
    endtask

    task automatic clear();
        cyc(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 2'b00); idle();
    endtask

    int n;
    int exp_pages [8] = '{1, 2, 3, 4, 5, 6, 0, 1};

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(ready_o[0]), 32'd1);
        chk("reset op_a", op_a_o[0], 32'h0);
        chk("reset start", 32'(start_o[1]), 32'd0);
        rst_n = 1'b1;
        idle();

        // Operand entry and start pulse
        load4(16'h40A0, 16'h0000, 16'h40E0, 16'h0000);
        chk("entry op_a", op_a_o[0], 32'h40A00000);
        chk("entry op_b", op_b_o[0], 32'h40E00000);
        chk("entry start", 32'(start_o[0]), 32'd1);
        chk("entry ready", 32'(ready_o[0]), 32'd0);

        // Done after 50 wait cycles, then eight page steps
        repeat (49) idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 2'b00);
        idle();
        chk("done show", 32'(show_o[0]), 32'd1);
        chk("done err", 32'(err_o[0]), 32'd0);
        chk("done page", 32'(page_o[0]), 32'd0);
        chk("short timed out err", 32'(err_o[1]), 32'd3);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 2'b00);
            idle();
            chk($sformatf("page step %0d", k), 32'(page_o[0]), 32'(exp_pages[k]));
        end

        // Timeout length on the short instance
        clear();
        load4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("tmo start", 32'(start_o[1]), 32'd1);
        n = 0;
        while (n < 40) begin
            idle();
            if (show_o[1]) break;
            n++;
        end
        chk("tmo wait cycles", 32'(n), 32'd16);
        chk("tmo err", 32'(err_o[1]), 32'd3);
        chk("tmo page", 32'(page_o[1]), 32'd0);

        // Clear after two words, then reload
        clear();
        cyc(1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 16'hBBBB, 1'b0, 2'b00);
        clear();
        chk("clr word_idx", 32'(idx_o[0]), 32'd0);
        chk("clr op_a", op_a_o[0], 32'h0);
        load4(16'h3F80, 16'h0000, 16'h4000, 16'h0000);
        chk("reload op_a", op_a_o[0], 32'h3F800000);
        chk("reload op_b", op_b_o[0], 32'h40000000);

        // Done coinciding with expiry on the short instance
        repeat (15) idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 2'b01);
        idle();
        chk("done wins show", 32'(show_o[1]), 32'd1);
        chk("done wins err", 32'(err_o[1]), 32'd1);

        // Clear together with the fourth word
        clear();
        cyc(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 16'h5678, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 16'h9ABC, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 16'hDEF0, 1'b0, 2'b00);
        idle();
        chk("clr4 start", 32'(start_o[0]), 32'd0);
        chk("clr4 ready", 32'(ready_o[0]), 32'd1);
        chk("clr4 op_b", op_b_o[0], 32'h0);
        idle();
        chk("clr4 no late start", 32'(start_o[0]), 32'd0);

        // Asynchronous reset between edges while waiting
        load4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        repeat (5) idle();
        #1 rst_n = 1'b0;
        #1;
        chk("async ready", 32'(ready_o[0]), 32'd1);
        chk("async op_a", op_a_o[0], 32'h0);
        chk("async op_b", op_b_o[1], 32'h0);
        chk("async show", 32'(show_o[0]), 32'd0);
        #2 rst_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 2), 16'($urandom),
                ($urandom_range(0, 99) < 4), 2'($urandom));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
